// File: rtl/mips_defs_pkg.sv
// mips_defs: shared datapath widths and named register indices (REG_ZERO, REG_RA)
package mips_defs;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PC_W = 32;
  localparam int REG_ZERO = 0;
  localparam int REG_RA = 31;
endpackage

// File: rtl/grf_read_port.sv
// grf_read_port: one GRF read port; ra/mem_q in, rd out; $0 forced to zero, write-through bypass from we/wa/wd while reset_n=1
module grf_read_port
  import mips_defs::*;
#(
  parameter int DW = mips_defs::DATA_W,
  parameter int AW = mips_defs::ADDR_W
) (
  input  logic          reset_n,
  input  logic [AW-1:0] ra,
  input  logic [DW-1:0] mem_q,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] rd
);
  always_comb rd = (ra == AW'(REG_ZERO)) ? '0 : (reset_n && we && wa == ra) ? wd : mem_q;
endmodule

// File: rtl/grf_wb_port.sv
// grf_wb_port: 32x32 register file; ra1/ra2->rd1/rd2 comb reads, we/wa/wd/wpc write, trace_* and wr_count registered commit log
module grf_wb_port
  import mips_defs::*;
#(
  parameter int DATA_W = mips_defs::DATA_W,
  parameter int ADDR_W = mips_defs::ADDR_W,
  parameter int PC_W = mips_defs::PC_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [PC_W-1:0]   wpc,
  output logic              trace_valid,
  output logic [PC_W-1:0]   trace_pc,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data,
  output logic [15:0]       wr_count
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic commit;
  always_comb commit = reset_n && we && wa != ADDR_W'(REG_ZERO);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
      trace_valid <= 1'b0;
      trace_pc <= '0;
      trace_addr <= '0;
      trace_data <= '0;
      wr_count <= '0;
    end else begin
      trace_valid <= commit;
      if (commit) begin
        mem[wa] <= wd;
        trace_pc <= wpc;
        trace_addr <= wa;
        trace_data <= wd;
        wr_count <= wr_count + 16'd1;
      end
    end
  end
  grf_read_port #(.DW(DATA_W), .AW(ADDR_W)) u_rp1 (
    .reset_n(reset_n), .ra(ra1), .mem_q(mem[ra1]), .we(we), .wa(wa), .wd(wd), .rd(rd1)
  );
  grf_read_port #(.DW(DATA_W), .AW(ADDR_W)) u_rp2 (
    .reset_n(reset_n), .ra(ra2), .mem_q(mem[ra2]), .we(we), .wa(wa), .wd(wd), .rd(rd2)
  );
endmodule

// File: tb/tb_grf_wb_port.sv
// tb_grf_wb_port: directed and randomized self-checking bench for grf_wb_port against a register-array model
module tb_grf_wb_port;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [4:0] ra1 = '0, ra2 = '0, wa = '0;
  logic [31:0] rd1, rd2, wd = '0, wpc = '0;
  logic we = 1'b0;
  logic trace_valid;
  logic [31:0] trace_pc, trace_data;
  logic [4:0] trace_addr;
  logic [15:0] wr_count;
  int tests = 0, fails = 0;
  logic [31:0] m [32];
  logic m_tv;
  logic [31:0] m_pc, m_data;
  logic [4:0] m_addr;
  int m_cnt;
  logic [15:0] cnt0;
  always #5 clk = ~clk;
  grf_wb_port dut (
    .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .wpc(wpc), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_addr(trace_addr), .trace_data(trace_data), .wr_count(wr_count)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (ra == 0) return 32'd0;
    if (reset_n && we && wa == ra) return wd;
    return m[ra];
  endfunction
  task automatic check_reads();
    chk("rd1", 64'(rd1), 64'(exp_rd(ra1)));
    chk("rd2", 64'(rd2), 64'(exp_rd(ra2)));
  endtask
  task automatic tick(input bit check);
    @(posedge clk);
    if (!reset_n) begin
      foreach (m[i]) m[i] = '0;
      m_tv = 0; m_pc = 0; m_addr = 0; m_data = 0; m_cnt = 0;
    end else if (we && wa != 0) begin
      m[wa] = wd;
      m_tv = 1; m_pc = wpc; m_addr = wa; m_data = wd;
      m_cnt = (m_cnt + 1) % 65536;
    end else m_tv = 0;
    #1;
    if (check) begin
      chk("trace_valid", 64'(trace_valid), 64'(m_tv));
      chk("wr_count", 64'(wr_count), 64'(m_cnt));
      if (m_tv) begin
        chk("trace_pc", 64'(trace_pc), 64'(m_pc));
        chk("trace_addr", 64'(trace_addr), 64'(m_addr));
        chk("trace_data", 64'(trace_data), 64'(m_data));
      end
    end
  endtask
  initial begin
    foreach (m[i]) m[i] = '0;
    m_tv = 0; m_pc = 0; m_addr = 0; m_data = 0; m_cnt = 0;
    // reset holds off a pending write
    reset_n = 0; we = 1; wa = 5; wd = 32'hDEADBEEF; wpc = 32'h100;
    tick(1); chk("rst_tv", 64'(trace_valid), 64'd0);
    tick(1); chk("rst_tv2", 64'(trace_valid), 64'd0);
    reset_n = 1; we = 0; ra1 = 5; ra2 = 0; #1;
    chk("rst_rd1", 64'(rd1), 64'd0);
    chk("rst_cnt", 64'(wr_count), 64'd0);
    check_reads();
    tick(1); chk("rst_tv3", 64'(trace_valid), 64'd0);
    // write-through bypass on both ports
    we = 1; wa = 8; wd = 32'h12345678; wpc = 32'h400; ra1 = 8; ra2 = 8; #1;
    chk("wt_rd1", 64'(rd1), 64'h12345678);
    chk("wt_rd2", 64'(rd2), 64'h12345678);
    tick(1);
    we = 0; #1;
    chk("wt_rd1_next", 64'(rd1), 64'h12345678);
    chk("wt_rd2_next", 64'(rd2), 64'h12345678);
    chk("wt_tv", 64'(trace_valid), 64'd1);
    chk("wt_taddr", 64'(trace_addr), 64'd8);
    chk("wt_tdata", 64'(trace_data), 64'h12345678);
    chk("wt_tpc", 64'(trace_pc), 64'h400);
    tick(1);
    // writes to $0 are dropped
    cnt0 = wr_count;
    we = 1; wa = 0; wd = 32'hFFFFFFFF; ra1 = 0; #1;
    chk("z_rd1", 64'(rd1), 64'd0);
    tick(1);
    we = 0; #1;
    chk("z_rd1_next", 64'(rd1), 64'd0);
    chk("z_tv", 64'(trace_valid), 64'd0);
    chk("z_cnt", 64'(wr_count), 64'(cnt0));
    // back-to-back writes to $31
    cnt0 = wr_count;
    we = 1; wa = 31; wd = 1; ra2 = 31;
    tick(1);
    chk("bb_tdata1", 64'(trace_data), 64'd1);
    wd = 2;
    tick(1);
    chk("bb_tv2", 64'(trace_valid), 64'd1);
    chk("bb_tdata2", 64'(trace_data), 64'd2);
    we = 0; #1;
    chk("bb_rd2", 64'(rd2), 64'd2);
    chk("bb_cnt", 64'(wr_count), 64'(cnt0 + 16'd2));
    tick(1);
    chk("bb_tv_off", 64'(trace_valid), 64'd0);
    // counter wrap
    reset_n = 0; tick(1); reset_n = 1;
    we = 1; wa = 1;
    for (int i = 0; i < 65535; i++) begin
      wd = i; tick(0);
    end
    chk("wrap_pre", 64'(wr_count), 64'hFFFF);
    wd = 32'hCAFE;
    tick(1);
    chk("wrap_cnt", 64'(wr_count), 64'd0);
    chk("wrap_tv", 64'(trace_valid), 64'd1);
    // randomized sweep with reset pulses
    for (int i = 0; i < 10000; i++) begin
      reset_n = ($urandom_range(63) != 0);
      we = $urandom_range(1);
      wa = $urandom_range(31) < 4 ? 5'd0 : 5'($urandom_range(31));
      wd = $urandom;
      wpc = $urandom;
      ra1 = $urandom_range(3) == 0 ? wa : 5'($urandom_range(31));
      ra2 = $urandom_range(3) == 0 ? wa : 5'($urandom_range(31));
      #1;
      check_reads();
      tick(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
